// File: rtl/m_lsu_pkg.sv
// Shared encodings and lane helpers for the memory-stage load/store initiator.
// No logic of its own; latency and backpressure live in m_lsu.
// Imported by m_lsu and m_lsu_align.
package m_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [1:0] lo);
    logic [3:0] be;
    case (sz)
      SZ_BYTE: be = 4'b0001 << lo;
      SZ_HALF: be = 4'b0011 << lo;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/m_lsu_align.sv
// Lane alignment: byte enables, replicated store data, misalign detect, load extension.
// Purely combinational, zero latency; no flow control.
// Caller muxes live vs. latched address/size so one instance serves both phases.
module m_lsu_align
  import m_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lo,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misalign,
  output logic [31:0] rd_ext
);

  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  always_comb begin
    be        = be_of(size, lo);
    misalign  = (size == SZ_HALF && lo[0]) ||
                (size == SZ_WORD && lo != 2'b00) ||
                (size == 2'd3);
    wdata_rep = wdata;
    case (size)
      SZ_BYTE: wdata_rep = {4{wdata[7:0]}};
      SZ_HALF: wdata_rep = {2{wdata[15:0]}};
      default: wdata_rep = wdata;
    endcase
  end

  always_comb begin
    ld_b   = rdata[{lo, 3'b000} +: 8];
    ld_h   = lo[1] ? rdata[31:16] : rdata[15:0];
    rd_ext = rdata;
    case (size)
      SZ_BYTE: rd_ext = {{24{sign_ext & ld_b[7]}}, ld_b};
      SZ_HALF: rd_ext = {{16{sign_ext & ld_h[15]}}, ld_h};
      default: rd_ext = rdata;
    endcase
  end

endmodule

// File: rtl/m_lsu.sv
// Memory-stage load/store initiator; optional store trace under M_LSU_TRACE_EN.
// Latency: store 3 cycles, load 4 cycles, rejected access 2 cycles (op cycle to done inclusive).
// Backpressure: holds the request stable while ready is low, waits indefinitely for rsp_valid.
module m_lsu
  import m_lsu_pkg::*;
#(
  parameter int MEM_WORDS = 3072
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic        op_valid,
  input  logic        op_store,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic        misalign,
  output logic [31:0] rd_data,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] MW = 32'(MEM_WORDS);

  state_t      state;
  logic [1:0]  lo_q;
  logic [1:0]  size_q;
  logic        sext_q;
  logic        store_q;

  logic [1:0]  a_lo;
  logic [1:0]  a_size;
  logic [3:0]  a_be;
  logic [31:0] a_wrep;
  logic        a_mis;
  logic [31:0] a_rd;
  logic        oor;
  logic        reject;

  // In IDLE the decision is made on the live op; afterwards the latched copy drives load extension.
  assign a_lo   = (state == IDLE) ? addr[1:0] : lo_q;
  assign a_size = (state == IDLE) ? size : size_q;
  assign oor    = {2'b00, addr[31:2]} >= MW;
  assign reject = a_mis | oor;

  assign stall = ((state == IDLE) && op_valid) || (state == REQ) || (state == RSP);

  m_lsu_align u_align (
    .size      (a_size),
    .lo        (a_lo),
    .sign_ext  (sext_q),
    .wdata     (wdata),
    .rdata     (mem_rdata),
    .be        (a_be),
    .wdata_rep (a_wrep),
    .misalign  (a_mis),
    .rd_ext    (a_rd)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      lo_q          <= 2'b00;
      size_q        <= SZ_BYTE;
      sext_q        <= 1'b0;
      store_q       <= 1'b0;
      done          <= 1'b0;
      misalign      <= 1'b0;
      rd_data       <= 32'h0;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_be        <= 4'h0;
      mem_addr      <= 32'h0;
      mem_wdata     <= 32'h0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (op_valid) begin
            lo_q      <= addr[1:0];
            size_q    <= size;
            sext_q    <= sign_ext;
            store_q   <= op_store;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_be    <= a_be;
            mem_wdata <= a_wrep;
            mem_we    <= op_store;
            if (reject) begin
              state    <= DONE;
              done     <= 1'b1;
              misalign <= 1'b1;
              rd_data  <= 32'h0;
            end else begin
              state         <= REQ;
              misalign      <= 1'b0;
              mem_req_valid <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            if (store_q) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RSP;
            end
          end
        end
        RSP: begin
          if (mem_rsp_valid) begin
            rd_data <= a_rd;
            state   <= DONE;
            done    <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          misalign <= 1'b0;
        end
      endcase
    end
  end

`ifdef M_LSU_TRACE_EN
  logic [31:0] pc_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= 32'h0;
    end else if (state == IDLE && op_valid) begin
      pc_q <= PC;
    end
  end

  always @(posedge clk) begin
    if (rst && state == REQ && mem_req_ready && store_q)
      $display("%d@%h: *%h <= %h", $time, pc_q, mem_addr, mem_wdata & lane_mask(mem_be));
  end
`else
  logic unused_pc;
  assign unused_pc = ^PC;
`endif

endmodule
